// File: rtl/ttt_pkg.sv
// Shared encodings, FSM states and win-line masks for the tic-tac-toe engine.
// No ports; imported by ttt_win_detect and ttt_game_engine.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_X    = 2'b01;
    localparam logic [1:0] W_O    = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        OVER  = 2'd2
    } state_t;

    // Index 0 is the highest-priority line: rows, cols, main diag, anti diag.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'b001010100,
        9'b100010001,
        9'b100100100,
        9'b010010010,
        9'b001001001,
        9'b111000000,
        9'b000111000,
        9'b000000111
    };

    function automatic logic [1:0] col_of(input logic [3:0] c);
        case (c)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line detector: finds the lowest-indexed complete line of a mark.
// Ports: board (18b), mark (2b) in; hit, line (9b cell mask) out.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  mark,
    output logic        hit,
    output logic [8:0]  line
);

    logic [8:0] own;

    always_comb begin
        own = '0;
        for (int i = 0; i < 9; i++) begin
            own[i] = (board[2*i +: 2] == mark);
        end
        line = '0;
        // Scan downward so the lowest-indexed match is the one kept.
        for (int l = 7; l >= 0; l--) begin
            if ((own & WIN_LINES[l]) == WIN_LINES[l]) begin
                line = WIN_LINES[l];
            end
        end
        hit = |line;
    end

endmodule

// File: rtl/ttt_game_engine.sv
// Tic-tac-toe game state: board, cursor, turn, win/draw and scores.
// Ports: clk, rst (sync, active low), up/down/left/right/place pulses in;
// board, cursor, turn, game_over, winner, win_line, score_x, score_o out.
// Optional macro TTT_CURSOR_WRAP_EN: cursor wraps instead of saturating.
module ttt_game_engine
    import ttt_pkg::*;
#(
    parameter int SCORE_MAX = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        place,
    output logic [17:0] board,
    output logic [3:0]  cursor,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic [8:0]  win_line,
    output logic [3:0]  score_x,
    output logic [3:0]  score_o
);

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  cursor_q, cursor_d;
    logic        turn_q, turn_d;
    logic        starter_q, starter_d;
    logic [1:0]  winner_q, winner_d;
    logic [8:0]  win_line_q, win_line_d;
    logic [3:0]  score_x_q, score_x_d;
    logic [3:0]  score_o_q, score_o_d;
    logic [3:0]  move_count_q, move_count_d;

    logic        hit;
    logic [8:0]  line;
    logic [1:0]  col;

    // In CHECK, turn_q still names the player who just moved.
    ttt_win_detect u_win (
        .board (board_q),
        .mark  (turn_q ? CELL_O : CELL_X),
        .hit   (hit),
        .line  (line)
    );

    assign col = col_of(cursor_q);

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        cursor_d     = cursor_q;
        turn_d       = turn_q;
        starter_d    = starter_q;
        winner_d     = winner_q;
        win_line_d   = win_line_q;
        score_x_d    = score_x_q;
        score_o_d    = score_o_q;
        move_count_d = move_count_q;

        unique case (state_q)
            PLAY: begin
                if (place) begin
                    if (board_q[{cursor_q, 1'b0} +: 2] == CELL_EMPTY) begin
                        board_d[{cursor_q, 1'b0} +: 2] = turn_q ? CELL_O : CELL_X;
                        move_count_d = move_count_q + 4'd1;
                        state_d      = CHECK;
                    end
                end else if (up) begin
                    if (cursor_q >= 4'd3) cursor_d = cursor_q - 4'd3;
`ifdef TTT_CURSOR_WRAP_EN
                    else cursor_d = cursor_q + 4'd6;
`endif
                end else if (down) begin
                    if (cursor_q <= 4'd5) cursor_d = cursor_q + 4'd3;
`ifdef TTT_CURSOR_WRAP_EN
                    else cursor_d = cursor_q - 4'd6;
`endif
                end else if (left) begin
                    if (col != 2'd0) cursor_d = cursor_q - 4'd1;
`ifdef TTT_CURSOR_WRAP_EN
                    else cursor_d = cursor_q + 4'd2;
`endif
                end else if (right) begin
                    if (col != 2'd2) cursor_d = cursor_q + 4'd1;
`ifdef TTT_CURSOR_WRAP_EN
                    else cursor_d = cursor_q - 4'd2;
`endif
                end
            end
            CHECK: begin
                if (hit) begin
                    winner_d   = turn_q ? W_O : W_X;
                    win_line_d = line;
                    if (turn_q) begin
                        if (score_o_q < SCORE_MAX[3:0]) score_o_d = score_o_q + 4'd1;
                    end else begin
                        if (score_x_q < SCORE_MAX[3:0]) score_x_d = score_x_q + 4'd1;
                    end
                    state_d = OVER;
                end else if (move_count_q == 4'd9) begin
                    winner_d = W_DRAW;
                    state_d  = OVER;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            OVER: begin
                if (place) begin
                    board_d      = '0;
                    winner_d     = W_NONE;
                    win_line_d   = '0;
                    move_count_d = '0;
                    cursor_d     = 4'd4;
                    starter_d    = ~starter_q;
                    turn_d       = ~starter_q;
                    state_d      = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= PLAY;
            board_q      <= '0;
            cursor_q     <= 4'd4;
            turn_q       <= 1'b0;
            starter_q    <= 1'b0;
            winner_q     <= W_NONE;
            win_line_q   <= '0;
            score_x_q    <= '0;
            score_o_q    <= '0;
            move_count_q <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            cursor_q     <= cursor_d;
            turn_q       <= turn_d;
            starter_q    <= starter_d;
            winner_q     <= winner_d;
            win_line_q   <= win_line_d;
            score_x_q    <= score_x_d;
            score_o_q    <= score_o_d;
            move_count_q <= move_count_d;
        end
    end

    assign board     = board_q;
    assign cursor    = cursor_q;
    assign turn      = turn_q;
    assign game_over = (state_q == OVER);
    assign winner    = winner_q;
    assign win_line  = win_line_q;
    assign score_x   = score_x_q;
    assign score_o   = score_o_q;

endmodule

// File: doc/ttt_game_engine.md
# ttt_game_engine

Tic-tac-toe game-state engine between the button debouncers and the VGA block renderer. It consumes single-cycle move pulses and maintains the 3x3 board, the cursor, the player turn, win/draw detection and per-player scores. Board, cursor and win-line outputs feed the renderer. Scores feed the seven-segment digit muxes in the top level.

## Interface
Parameters:
- SCORE_MAX, default 9: saturation value of each score counter (one decimal SSD digit).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- up, down, left, right  input  1 each  single-cycle cursor-move pulses, already debounced and one-shot upstream.
- place  input  1  single-cycle pulse. Places a mark in PLAY; starts a new game in OVER.
- board  output  18  cell i at bits [2i+1:2i], i = 3*row + col. Encoding: 00 empty, 01 X, 10 O.
- cursor  output  4  cell index 0..8.
- turn  output  1  player to move: 0 = X, 1 = O.
- game_over  output  1  high in state OVER.
- winner  output  2  00 none/in progress, 01 X, 10 O, 11 draw.
- win_line  output  9  one-hot-per-cell mask of the winning line; 0 if none.
- score_x, score_o  output  4 each  wins per player, saturating.

## Operation
- Reset (rst = 0 at a clk edge):
  - board = 0, cursor = 4, turn = 0, state = PLAY.
  - winner = 00, win_line = 0, scores = 0, move_count = 0.
  - starter = X.
- One action per cycle. Priority: place > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- PLAY:
  - Cursor moves:
    - up: row-1. down: row+1. left: col-1. right: col+1.
    - Edge behaviour depends on TTT_CURSOR_WRAP_EN.
  - place on an empty cell:
    - write mark (01 if turn = 0, else 10).
    - move_count+1.
    - go to CHECK.
  - place on an occupied cell is ignored; state is unchanged.
- CHECK: evaluate all 8 lines (3 rows, 3 cols, 2 diagonals) for the player who just moved.
  - Win: winner = that player; win_line = the lowest-indexed matching line (order: rows 0-2, cols 0-2, main diag, anti-diag); score+1, saturating at SCORE_MAX; go to OVER.
  - Else if move_count = 9: winner = 11; go to OVER.
  - Else: toggle turn; go to PLAY.
  - All inputs are ignored in CHECK.
- OVER:
  - Movement pulses are ignored.
  - place starts a new game:
    - clear board, winner, win_line and move_count.
    - cursor = 4.
    - starter toggles; turn = new starter.
    - go to PLAY. Scores are retained.
- move_count is 4 bits and never exceeds 9.

## Timing
- place accepted at edge N:
  - board shows the new mark from N+1; state = CHECK at N+1.
  - winner, win_line, game_over, score update and turn toggle are all visible from N+2.
- Cursor move accepted at edge N: new cursor value visible from N+1.
- New-game place accepted at edge N: cleared board and PLAY from N+1.
- All outputs are registered. No combinational input-to-output paths.
- Reset has priority over every event, including a reset in CHECK or OVER. Every output takes its reset value at the first edge with rst = 0.

## Configuration
- TTT_CURSOR_WRAP_EN defined: the cursor wraps within its row or column.
  - left at col 0 → col 2. right at col 2 → col 0.
  - up at row 0 → row 2. down at row 2 → row 0.
- Not defined: the cursor saturates. A move past an edge leaves the cursor unchanged.

## Structure
- Package ttt_pkg:
  - cell encodings: CELL_EMPTY, CELL_X, CELL_O.
  - winner encodings: W_NONE, W_X, W_O, W_DRAW.
  - state enum: PLAY, CHECK, OVER.
  - constant table of the 8 win-line masks (9 bits each).
- Sub-module ttt_win_detect: combinational.
  - Inputs: board, player mark.
  - Outputs: hit, line mask using lowest-index priority.
  - Instantiated once in CHECK.

## Test plan
- Reset, then right, right, down → cursor 4 → 5 → 5 (wrap off) or 3 (wrap on) → then 8 or 6.
- X places 0, O places 3, X places 1, O places 4, X places 2 → at the second cycle after the last place: winner = 01, win_line = 9'b000000111, score_x = 1, game_over = 1.
- Place on an occupied cell (X on 4, O presses place on 4) → board unchanged, turn stays O, state PLAY.
- Fill the board with no line (X: 0,2,3,7,8; O: 1,4,5,6) → winner = 11, no score change. Next place → board = 0 and turn = O (starter alternated).
- up and place pulsed in the same cycle → only the place takes effect; cursor unchanged.
- Ten consecutive X wins → score_x saturates at 9. Assert rst = 0 while in CHECK → all outputs at reset values at the next edge.
